// File: rtl/reg_bus_master_if.sv
// ----------------------------------------------------------------------------
// reg_bus_master_if
// Bundles the three sides of reg_bus_master into one interface:
//   command side  : cmd_valid/cmd_ready handshake with cmd_op, cmd_addr,
//                   cmd_wdata, cmd_mask
//   register bus  : cs, rw, addr, wdata driven by the master, rdata returned
//                   combinationally by the addressed slave
//   response side : rsp_valid/rsp_ready handshake with rsp_data, rsp_err
// Modports:
//   master : view of the reg_bus_master itself
//   slave  : view of the environment (host glue + register slaves)
// ----------------------------------------------------------------------------
interface reg_bus_master_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [DW-1:0] cmd_mask;
  logic          cs;
  logic          rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rdata, rsp_ready,
    output cmd_ready, cs, rw, addr, wdata, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rdata, rsp_ready,
    input  cmd_ready, cs, rw, addr, wdata, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/reg_bus_master.sv
// ----------------------------------------------------------------------------
// reg_bus_master
// Register-bus initiator. Accepts one command at a time from the host side and
// runs single-cycle bus accesses: write, read, read-modify-write, or
// poll-until-match, then returns exactly one response.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active-high; clears every output and the FSM
//   bus  : reg_bus_master_if.master (command, register bus, response signals)
//
// Parameters:
//   AW, DW    : bus address / data width
//   POLL_MAX  : read attempts allowed for a poll command (>= 1)
//   POLL_GAP  : idle cycles between poll reads (>= 0)
//
// Build option:
//   REG_BUS_MASTER_POLL_EN : when defined, op 11 polls the target register.
//   When undefined the poll engine, attempt counter and GAP state are absent
//   and op 11 answers immediately with rsp_err=1, rsp_data=0 and no bus cycle.
// ----------------------------------------------------------------------------
module reg_bus_master #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int POLL_MAX = 16,
  parameter int POLL_GAP = 4
) (
  input logic              clk,
  input logic              rst,
  reg_bus_master_if.master bus
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_RMW   = 2'b10;

`ifdef REG_BUS_MASTER_POLL_EN
  localparam logic [1:0] OP_POLL = 2'b11;
  // att_r counts completed reads (0..POLL_MAX-1), gap_r counts down idle cycles.
  localparam int ATT_W = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_GAP  = 3'd3,
    ST_RESP = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_RESP = 3'd4
  } state_t;
`endif

  // Replace the masked bits of old_v with the corresponding bits of new_v.
  function automatic logic [DW-1:0] merge_bits(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [DW-1:0] mask_v);
    return (old_v & ~mask_v) | (new_v & mask_v);
  endfunction

`ifdef REG_BUS_MASTER_POLL_EN
  // True when every masked bit of a equals the same bit of b.
  function automatic logic bits_match(input logic [DW-1:0] a,
                                      input logic [DW-1:0] b,
                                      input logic [DW-1:0] mask_v);
    return ((a ^ b) & mask_v) == {DW{1'b0}};
  endfunction
`endif

  state_t        state_r;
  logic [1:0]    op_r;
  logic [DW-1:0] wd_r;
  logic [DW-1:0] mask_r;
  logic          cmd_ready_r;
  logic          cs_r;
  logic          rw_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic          rsp_valid_r;
  logic [DW-1:0] rsp_data_r;
  logic          rsp_err_r;
`ifdef REG_BUS_MASTER_POLL_EN
  logic [ATT_W-1:0] att_r;
  logic [GAP_W-1:0] gap_r;
`endif

  // Controller: sequences the bus cycles and owns every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      op_r        <= 2'b00;
      wd_r        <= {DW{1'b0}};
      mask_r      <= {DW{1'b0}};
      cmd_ready_r <= 1'b0;
      cs_r        <= 1'b0;
      rw_r        <= 1'b0;
      addr_r      <= {AW{1'b0}};
      wdata_r     <= {DW{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DW{1'b0}};
      rsp_err_r   <= 1'b0;
`ifdef REG_BUS_MASTER_POLL_EN
      att_r       <= {ATT_W{1'b0}};
      gap_r       <= {GAP_W{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_r) begin
            // Latch the command; fields are never resampled afterwards.
            cmd_ready_r <= 1'b0;
            op_r        <= bus.cmd_op;
            wd_r        <= bus.cmd_wdata;
            mask_r      <= bus.cmd_mask;
            case (bus.cmd_op)
              OP_WRITE: begin
                state_r <= ST_WR;
                cs_r    <= 1'b1;
                rw_r    <= 1'b1;
                addr_r  <= bus.cmd_addr;
                wdata_r <= bus.cmd_wdata;
              end
              OP_READ, OP_RMW: begin
                state_r <= ST_RD;
                cs_r    <= 1'b1;
                rw_r    <= 1'b0;
                addr_r  <= bus.cmd_addr;
              end
`ifdef REG_BUS_MASTER_POLL_EN
              OP_POLL: begin
                state_r <= ST_RD;
                cs_r    <= 1'b1;
                rw_r    <= 1'b0;
                addr_r  <= bus.cmd_addr;
                att_r   <= {ATT_W{1'b0}};
              end
`endif
              default: begin
                // Unsupported op: answer at once with an error, no bus cycle.
                state_r     <= ST_RESP;
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= {DW{1'b0}};
                rsp_err_r   <= 1'b1;
              end
            endcase
          end else begin
            // Also raises cmd_ready one edge after reset release.
            cmd_ready_r <= 1'b1;
          end
        end

        ST_RD: begin
          // rdata is valid in this cycle and is captured on this edge.
          case (op_r)
            OP_RMW: begin
              // cs stays high: the write cycle follows the read directly.
              state_r <= ST_WR;
              rw_r    <= 1'b1;
              wdata_r <= merge_bits(bus.rdata, wd_r, mask_r);
            end
`ifdef REG_BUS_MASTER_POLL_EN
            OP_POLL: begin
              att_r <= att_r + 1'b1;
              if (bits_match(bus.rdata, wd_r, mask_r)) begin
                state_r     <= ST_RESP;
                cs_r        <= 1'b0;
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= bus.rdata;
                rsp_err_r   <= 1'b0;
              end else if (att_r == ATT_W'(POLL_MAX - 1)) begin
                state_r     <= ST_RESP;
                cs_r        <= 1'b0;
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= bus.rdata;
                rsp_err_r   <= 1'b1;
              end else if (POLL_GAP == 0) begin
                // No idle gap configured: the next read starts right away.
                state_r <= ST_RD;
                cs_r    <= 1'b1;
              end else begin
                state_r <= ST_GAP;
                cs_r    <= 1'b0;
                gap_r   <= GAP_W'(POLL_GAP - 1);
              end
            end
`endif
            default: begin
              state_r     <= ST_RESP;
              cs_r        <= 1'b0;
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= bus.rdata;
              rsp_err_r   <= 1'b0;
            end
          endcase
        end

        ST_WR: begin
          state_r     <= ST_RESP;
          cs_r        <= 1'b0;
          rsp_valid_r <= 1'b1;
          rsp_data_r  <= wdata_r;
          rsp_err_r   <= 1'b0;
        end

`ifdef REG_BUS_MASTER_POLL_EN
        ST_GAP: begin
          if (gap_r == {GAP_W{1'b0}}) begin
            state_r <= ST_RD;
            cs_r    <= 1'b1;
            rw_r    <= 1'b0;
          end else begin
            gap_r <= gap_r - 1'b1;
          end
        end
`endif

        ST_RESP: begin
          // Response held until consumed; cmd_ready returns the next cycle.
          if (bus.rsp_ready) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
          end else begin
            state_r <= ST_RESP;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          cs_r        <= 1'b0;
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.cs        = cs_r;
  assign bus.rw        = rw_r;
  assign bus.addr      = addr_r;
  assign bus.wdata     = wdata_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_reg_bus_master.sv
// ----------------------------------------------------------------------------
// tb_reg_bus_master
// Drives reg_bus_master with directed and random commands. Expected bus cycles
// and responses are queued when each command is issued; a monitor on the
// falling edge pops and compares them whenever cs or rsp_valid is seen.
// Bench slave: register 0x10 returns a programmed sequence (the counter),
// every other address is a writable register with a fixed power-up pattern.
// ----------------------------------------------------------------------------
module tb_reg_bus_master;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int PM = 3;
  localparam int PG = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_bus_master_if #(.AW(AW), .DW(DW)) ifc ();

  reg_bus_master #(.AW(AW), .DW(DW), .POLL_MAX(PM), .POLL_GAP(PG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { logic [31:0] data; logic err; int lat; } rsp_t;
  typedef struct { logic rw; logic [7:0] addr; logic [31:0] wdata; } bus_t;
  rsp_t rsp_q[$];
  bus_t bus_q[$];

  // ---------------- bench slave ----------------
  logic [31:0] smem [256];
  bit          swr  [256];
  logic [31:0] pv   [PM];
  int          rd10_cnt = 0;
  int          poll_base = 0;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return {a, ~a, a, 8'h5C};
  endfunction

  always_comb begin
    int k;
    k = rd10_cnt - poll_base;
    if (k < 0) k = 0;
    if (k > PM - 1) k = PM - 1;
    ifc.rdata = 32'hDEAD_BEEF;
    if (ifc.cs && !ifc.rw) begin
      if (ifc.addr == 8'h10)     ifc.rdata = pv[k];
      else if (swr[ifc.addr])    ifc.rdata = smem[ifc.addr];
      else                       ifc.rdata = init_val(ifc.addr);
    end
  end

  always @(posedge clk) begin
    if (ifc.cs && ifc.rw && ifc.addr != 8'h10) begin
      smem[ifc.addr] <= ifc.wdata;
      swr[ifc.addr]  <= 1'b1;
    end
    if (ifc.cs && !ifc.rw && ifc.addr == 8'h10) rd10_cnt <= rd10_cnt + 1;
  end

  // ---------------- reference model ----------------
  logic [31:0] mmem [256];
  bit          mwr  [256];

  function automatic logic [31:0] model_rd(input logic [7:0] a);
    return mwr[a] ? mmem[a] : init_val(a);
  endfunction

  // ---------------- monitor ----------------
  int          cyc = 0;
  int          acc_cyc = 0;
  int          hs_cnt = 0;
  bit          in_rsp = 1'b0;
  bit          hs_prev = 1'b0;
  logic [31:0] hold_d;
  logic        hold_e;
  rsp_t        me;
  bus_t        mb;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      in_rsp  = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) begin
        check("cmd_ready_after_hs", ifc.cmd_ready, 1);
        check("rsp_valid_after_hs", ifc.rsp_valid, 0);
      end
      hs_prev = 1'b0;
      if (ifc.cmd_valid && ifc.cmd_ready) acc_cyc = cyc;
      if (ifc.cs) begin
        if (bus_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL bus_unexpected: got cs=1 addr=0x%0h rw=%0b expected no bus cycle", ifc.addr, ifc.rw);
        end else begin
          mb = bus_q.pop_front();
          check("bus_rw", ifc.rw, mb.rw);
          check("bus_addr", ifc.addr, mb.addr);
          if (mb.rw) check("bus_wdata", ifc.wdata, mb.wdata);
        end
      end
      if (ifc.rsp_valid) begin
        check("cmd_ready_in_resp", ifc.cmd_ready, 0);
        if (!in_rsp) begin
          in_rsp = 1'b1;
          hold_d = ifc.rsp_data;
          hold_e = ifc.rsp_err;
          if (rsp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rsp_unexpected: got data=0x%0h err=%0b expected no response", ifc.rsp_data, ifc.rsp_err);
          end else begin
            me = rsp_q.pop_front();
            check("rsp_data", ifc.rsp_data, me.data);
            check("rsp_err", ifc.rsp_err, me.err);
            check("rsp_latency", cyc - acc_cyc, me.lat);
          end
        end else begin
          check("rsp_data_stable", ifc.rsp_data, hold_d);
          check("rsp_err_stable", ifc.rsp_err, hold_e);
        end
        if (ifc.rsp_ready) begin
          hs_prev = 1'b1;
          in_rsp  = 1'b0;
          hs_cnt++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic void push_bus(input logic rw, input logic [7:0] a, input logic [31:0] wd);
    bus_t b;
    b.rw = rw; b.addr = a; b.wdata = wd;
    bus_q.push_back(b);
  endfunction

  // Compute the expected bus traffic and response for a command.
  task automatic expect_cmd(input logic [1:0] op, input logic [7:0] a,
                            input logic [31:0] wd, input logic [31:0] m);
    rsp_t e;
    logic [31:0] nv;
    int nrd;
    bit done;
    case (op)
      2'b00: begin
        push_bus(1'b1, a, wd);
        mmem[a] = wd; mwr[a] = 1'b1;
        e.data = wd; e.err = 1'b0; e.lat = 2;
      end
      2'b01: begin
        push_bus(1'b0, a, 32'h0);
        e.data = model_rd(a); e.err = 1'b0; e.lat = 2;
      end
      2'b10: begin
        nv = (model_rd(a) & ~m) | (wd & m);
        push_bus(1'b0, a, 32'h0);
        push_bus(1'b1, a, nv);
        mmem[a] = nv; mwr[a] = 1'b1;
        e.data = nv; e.err = 1'b0; e.lat = 3;
      end
      default: begin
`ifdef REG_BUS_MASTER_POLL_EN
        poll_base = rd10_cnt;
        nrd = 0; done = 1'b0;
        e.data = 32'h0; e.err = 1'b1;
        for (int i = 0; i < PM && !done; i++) begin
          nrd++;
          push_bus(1'b0, a, 32'h0);
          e.data = pv[i];
          if (((pv[i] ^ wd) & m) == 32'h0) begin
            e.err = 1'b0; done = 1'b1;
          end
        end
        e.lat = nrd + (nrd - 1) * PG + 1;
`else
        nrd = 0; done = 1'b0;
        e.data = 32'h0; e.err = 1'b1; e.lat = 1 + nrd + int'(done);
`endif
      end
    endcase
    rsp_q.push_back(e);
  endtask

  // Called at posedge+1: wait for cmd_ready, present the command for one edge.
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] a,
                          input logic [31:0] wd, input logic [31:0] m);
    int g;
    g = 0;
    while (ifc.cmd_ready !== 1'b1 && g < 50) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL cmd_ready_timeout: got cmd_ready=%0b expected 1 within 50 cycles", ifc.cmd_ready);
    end
    ifc.cmd_op = op; ifc.cmd_addr = a; ifc.cmd_wdata = wd; ifc.cmd_mask = m;
    ifc.cmd_valid = 1'b1;
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 2'($urandom);
    ifc.cmd_addr  = 8'($urandom);
    ifc.cmd_wdata = $urandom;
    ifc.cmd_mask  = $urandom;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a,
                       input logic [31:0] wd, input logic [31:0] m, input int hold);
    int g;
    int h0;
    expect_cmd(op, a, wd, m);
    send_cmd(op, a, wd, m);
    if (hold > 0) begin
      g = 0;
      while (ifc.rsp_valid !== 1'b1 && g < 40) begin
        @(posedge clk); #1; g++;
      end
      for (int i = 0; i < hold; i++) begin
        ifc.cmd_valid = i[0];
        check("cmd_ready_bp", ifc.cmd_ready, 0);
        check("rsp_valid_bp", ifc.rsp_valid, 1);
        @(posedge clk); #1;
      end
      ifc.cmd_valid = 1'b0;
    end
    h0 = hs_cnt;
    g = 0;
    while (hs_cnt == h0 && g < 100) begin
      ifc.rsp_ready = (hold > 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); #1; g++;
    end
    ifc.rsp_ready = 1'b0;
    if (hs_cnt == h0) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_timeout: got no handshake expected one within 100 cycles");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  op;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [31:0] m;
    int          idx;
    rst = 1'b1;
    ifc.cmd_valid = 1'b0; ifc.cmd_op = 2'b00; ifc.cmd_addr = 8'h00;
    ifc.cmd_wdata = 32'h0; ifc.cmd_mask = 32'h0; ifc.rsp_ready = 1'b0;
    for (int i = 0; i < PM; i++) pv[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", ifc.cmd_ready, 0);
    check("rst_cs", ifc.cs, 0);
    check("rst_rw", ifc.rw, 0);
    check("rst_addr", ifc.addr, 0);
    check("rst_wdata", ifc.wdata, 0);
    check("rst_rsp_valid", ifc.rsp_valid, 0);
    check("rst_rsp_data", ifc.rsp_data, 0);
    check("rst_rsp_err", ifc.rsp_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("cmd_ready_after_rst", ifc.cmd_ready, 1);

    // Directed: write, read back, RMW on register 0x03.
    issue(2'b00, 8'h03, 32'h0000_00A5, 32'h0, 0);
    issue(2'b01, 8'h03, 32'h0, 32'h0, 0);
    issue(2'b10, 8'h03, 32'h0000_000F, 32'h0000_000F, 0);
    issue(2'b01, 8'h03, 32'h0, 32'h0, 0);

    // Poll success on the third read, then poll timeout.
    pv[0] = 32'h00; pv[1] = 32'h00; pv[2] = 32'h07;
    issue(2'b11, 8'h10, 32'h07, 32'hFF, 0);
    pv[0] = 32'h01; pv[1] = 32'h02; pv[2] = 32'h03;
    issue(2'b11, 8'h10, 32'h07, 32'hFF, 0);

    // Backpressure: response held for 10 cycles with stray cmd_valid pulses.
    issue(2'b00, 8'h03, 32'h1234_5678, 32'h0, 10);
    issue(2'b11, 8'h10, 32'h07, 32'hFF, 10);

    // Reset in the middle of an operation.
`ifdef REG_BUS_MASTER_POLL_EN
    pv[0] = 32'h01; pv[1] = 32'h02; pv[2] = 32'h03;
    poll_base = rd10_cnt;
    push_bus(1'b0, 8'h10, 32'h0);
    send_cmd(2'b11, 8'h10, 32'h07, 32'hFF);
    @(posedge clk); #2;
`else
    push_bus(1'b0, 8'h03, 32'h0);
    begin
      rsp_t e;
      e.data = model_rd(8'h03); e.err = 1'b0; e.lat = 2;
      rsp_q.push_back(e);
    end
    send_cmd(2'b01, 8'h03, 32'h0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #2;
`endif
    rst = 1'b1;
    #1;
    check("midrst_cs", ifc.cs, 0);
    check("midrst_rsp_valid", ifc.rsp_valid, 0);
    check("midrst_cmd_ready", ifc.cmd_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_cmd_ready_rel", ifc.cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("midrst_no_stale_rsp", ifc.rsp_valid, 0);
      check("midrst_no_cs", ifc.cs, 0);
      @(posedge clk); #1;
    end

    // Random commands.
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      wd = $urandom;
      m  = $urandom | 32'h1;
      if (op == 2'b11) begin
        a = 8'h10;
        for (int i = 0; i < PM; i++) pv[i] = $urandom;
        idx = $urandom_range(0, PM);
        if (idx < PM) pv[idx] = ($urandom & ~m) | (wd & m);
      end else begin
        a = ($urandom_range(0, 1) == 0) ? 8'h03 : 8'($urandom);
        if (a == 8'h10) a = 8'h03;
      end
      issue(op, a, wd, m, ($urandom_range(0, 7) == 0) ? 3 : 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("bus_q_drained", bus_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
- Initiator for the cs/rw/addr/wdata/rdata register bus used by the counter register blocks.
- Takes commands from a host-side valid/ready interface and runs single bus cycles: write, read, read-modify-write, or poll-until-match.
- Returns one response per command.
- Sits between the host/CPU glue and one or more register slaves; the slaves share rdata through the address decode.

Parameters:
AW, 8, bus address width
DW, 32, bus data width
POLL_MAX, 16, maximum read attempts for a poll command (>=1)
POLL_GAP, 4, idle cycles between poll reads (>=0)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready at posedge
cmd_op  in  2  00 write, 01 read, 10 read-modify-write, 11 poll
cmd_addr  in  AW  target register address
cmd_wdata  in  DW  write data / compare value
cmd_mask  in  DW  RMW/poll bit mask
cs  out  1  bus chip select
rw  out  1  1=write, 0=read
addr  out  AW  bus address
wdata  out  DW  bus write data
rdata  in  DW  bus read data; slave drives it combinationally in the same cycle as cs&~rw
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready at posedge
rsp_data  out  DW  read data / final written data
rsp_err  out  1  poll timeout or unsupported op

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- All outputs are registered. Reset forces all outputs to 0 and the state to IDLE, including mid-operation; cs deasserts immediately.
- States: IDLE, RD, WR, GAP, RESP.
- cmd_ready = 1 only in IDLE. Command fields are latched on the accept edge and are not resampled.
- Each bus cycle is exactly one clk cycle with cs=1. rdata is sampled on the posedge that ends a read cycle. cs=0 in all other states; addr and wdata hold their last values when cs=0.
- Write (00), accepted at edge N:
  - Cycle N+1: WR, cs=1, rw=1, wdata=cmd_wdata.
  - Cycle N+2: RESP, rsp_data=cmd_wdata, rsp_err=0.
- Read (01):
  - Cycle N+1: RD, cs=1, rw=0.
  - Cycle N+2: RESP, rsp_data=sampled rdata.
- RMW (10):
  - Cycle N+1: RD.
  - Cycle N+2: WR with wdata=(rd&~mask)|(cmd_wdata&mask).
  - Cycle N+3: RESP, rsp_data=the written value.
- Poll (11):
  - Each read goes RD; a match is (rdata&mask)==(cmd_wdata&mask).
  - On match: RESP with rsp_data=rdata, rsp_err=0.
  - On mismatch with attempts < POLL_MAX: go to GAP for POLL_GAP cycles, then RD again. With POLL_GAP=0, RD follows RD directly.
  - On mismatch of attempt POLL_MAX: RESP with rsp_err=1, rsp_data=last rdata.
  - Attempt counter is cleared on accept.
- RESP: rsp_valid=1; rsp_data and rsp_err held stable until rsp_ready. On the rsp_valid&rsp_ready edge, return to IDLE; cmd_ready=1 the following cycle (no back-to-back overlap). rsp_valid=0 outside RESP.
- Only one command is outstanding at a time. cmd_valid is ignored outside IDLE.
- Masks are applied bitwise at full DW width. No arithmetic overflow cases exist.

Optional Feature:
- Macro REG_BUS_MASTER_POLL_EN.
- Defined: op 11 behaves as above.
- Undefined:
  - The poll logic, attempt counter and GAP state are not built.
  - Op 11 is accepted, issues no bus cycle (cs stays 0), and goes directly to RESP at N+1 with rsp_err=1, rsp_data=0.

Test Plan:
- Bench slave: register 0x03 is writable; register 0x10 reads the counter input.
- Write: cmd op=00 addr=0x03 wdata=0x000000A5 -> one cycle cs=1 rw=1 addr=0x03 wdata=0xA5; rsp_valid at N+2, rsp_data=0xA5, rsp_err=0; a following read of 0x03 returns 0xA5.
- RMW: slave 0x03=0xA5; cmd op=10 wdata=0x0F mask=0x0F -> RD then WR of 0xAF on consecutive cycles; rsp_data=0xAF at N+3.
- Poll success:
  - Counter reads 0x00,0x00,0x07; cmd op=11 addr=0x10 wdata=0x07 mask=0xFF, POLL_GAP=4.
  - Expect three cs pulses spaced 5 cycles apart.
  - Response: rsp_data=0x07, rsp_err=0.
- Poll timeout: POLL_MAX=3, value never matches -> exactly 3 read cycles, rsp_err=1, rsp_data=last read value. With macro undefined: no cs pulse, rsp_err=1 at N+1.
- Backpressure/handshake: hold rsp_ready=0 for 10 cycles -> rsp_valid, rsp_data and rsp_err stable; cmd_ready=0 throughout; cmd_valid pulses are ignored; cmd_ready rises the cycle after the rsp handshake.
- Reset mid-operation: assert rst during the GAP state of a poll -> cs, rsp_valid and cmd_ready=0 asynchronously; after release, IDLE with cmd_ready=1 next edge and no stale response.
